// File: rtl/alu_rs_scheduler_pkg.sv
// ============================================================================
// Module      : alu_rs_scheduler_pkg
// Description : Shared widths, opcode encodings and entry-count default for
//               the ALU reservation station. Machine-wide widths normally come
//               from global_params.v; the guarded defaults below apply only if
//               that file has not already defined them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef ALU_RS_SIZE_WIDTH
`define ALU_RS_SIZE_WIDTH 3
`endif

package alu_rs_scheduler_pkg;

    localparam int XLEN              = `XLEN;
    localparam int ALU_OP_WIDTH      = `ALU_OP_WIDTH;
    localparam int ROB_SIZE_WIDTH    = `ROB_SIZE_WIDTH;
    localparam int ALU_RS_SIZE_WIDTH = `ALU_RS_SIZE_WIDTH;

    // ALU opcode encodings shared by decoder, scheduler and ALU
    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/alu_rs_scheduler_picker.sv
// ============================================================================
// Module      : rs_picker
// Description : Lowest-index set-bit finder. Returns whether any bit is set
//               and the index of the lowest one (zero when none is set).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_picker #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_rs_scheduler.sv
// ============================================================================
// Module      : alu_rs_scheduler
// Description : Reservation station for the integer ALU. Accepts one dispatch
//               per cycle, captures pending operands from the ALU and LSB
//               result broadcasts, and issues the lowest-index ready entry
//               into the single-cycle ALU through registered rs_* outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
#(
    parameter int RS_SIZE_WIDTH = ALU_RS_SIZE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      dec_valid,
    input  logic [ALU_OP_WIDTH-1:0]   dec_op,
    input  logic [XLEN-1:0]           dec_val1,
    input  logic [XLEN-1:0]           dec_val2,
    input  logic                      dec_dep1,
    input  logic                      dec_dep2,
    input  logic [ROB_SIZE_WIDTH-1:0] dec_tag1,
    input  logic [ROB_SIZE_WIDTH-1:0] dec_tag2,
    input  logic [ROB_SIZE_WIDTH-1:0] dec_id,
    input  logic                      alu_ready,
    input  logic [XLEN-1:0]           alu_res,
    input  logic [ROB_SIZE_WIDTH-1:0] alu_id,
    input  logic                      lsb_ready,
    input  logic [XLEN-1:0]           lsb_res,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_id,
    output logic                      rs_full,
    output logic                      rs_ready,
    output logic [ALU_OP_WIDTH-1:0]   rs_op,
    output logic [XLEN-1:0]           rs_val1,
    output logic [XLEN-1:0]           rs_val2,
    output logic [ROB_SIZE_WIDTH-1:0] rs_id
);

    localparam int N = 1 << RS_SIZE_WIDTH;

    // Entry storage, one array per field
    logic [N-1:0]              r_busy;
    logic [N-1:0]              r_dep1;
    logic [N-1:0]              r_dep2;
    logic [ALU_OP_WIDTH-1:0]   r_op   [N];
    logic [XLEN-1:0]           r_val1 [N];
    logic [XLEN-1:0]           r_val2 [N];
    logic [ROB_SIZE_WIDTH-1:0] r_tag1 [N];
    logic [ROB_SIZE_WIDTH-1:0] r_tag2 [N];
    logic [ROB_SIZE_WIDTH-1:0] r_id   [N];

    logic [N-1:0]              w_free;
    logic [N-1:0]              w_ready;
    logic                      w_free_found;
    logic [RS_SIZE_WIDTH-1:0]  w_free_idx;
    logic                      w_issue_found;
    logic [RS_SIZE_WIDTH-1:0]  w_issue_idx;
    logic                      w_disp;

    logic [N-1:0]              w_wk1;
    logic [N-1:0]              w_wk2;
    logic [XLEN-1:0]           w_wk1_val [N];
    logic [XLEN-1:0]           w_wk2_val [N];

    logic [XLEN-1:0]           w_disp_val1;
    logic [XLEN-1:0]           w_disp_val2;
    logic                      w_disp_dep1;
    logic                      w_disp_dep2;

    // Readiness uses registered state only, so a same-cycle wakeup waits a cycle
    assign w_free  = ~r_busy;
    assign w_ready = r_busy & ~r_dep1 & ~r_dep2;
    assign rs_full = &r_busy;
    // A dispatch into a full station is illegal and simply ignored
    assign w_disp  = dec_valid & w_free_found;

    rs_picker #(
        .WIDTH (N),
        .IDX_W (RS_SIZE_WIDTH)
    ) u_free_pick (
        .i_vec   (w_free),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    rs_picker #(
        .WIDTH (N),
        .IDX_W (RS_SIZE_WIDTH)
    ) u_ready_pick (
        .i_vec   (w_ready),
        .o_found (w_issue_found),
        .o_idx   (w_issue_idx)
    );

    // Per-entry tag match against both broadcast buses; ALU wins on a tie
    for (genvar i = 0; i < N; i++) begin : g_wakeup
        logic w_a1, w_l1, w_a2, w_l2;
        assign w_a1         = alu_ready && (alu_id == r_tag1[i]);
        assign w_l1         = lsb_ready && (lsb_id == r_tag1[i]);
        assign w_a2         = alu_ready && (alu_id == r_tag2[i]);
        assign w_l2         = lsb_ready && (lsb_id == r_tag2[i]);
        assign w_wk1[i]     = r_busy[i] && r_dep1[i] && (w_a1 || w_l1);
        assign w_wk2[i]     = r_busy[i] && r_dep2[i] && (w_a2 || w_l2);
        assign w_wk1_val[i] = w_a1 ? alu_res : lsb_res;
        assign w_wk2_val[i] = w_a2 ? alu_res : lsb_res;
    end

    // Dispatch bypass: an operand produced by a broadcast this cycle is captured directly
    always_comb begin
        w_disp_val1 = dec_val1;
        w_disp_dep1 = dec_dep1;
        w_disp_val2 = dec_val2;
        w_disp_dep2 = dec_dep2;
        if (dec_dep1) begin
            if (alu_ready && alu_id == dec_tag1) begin
                w_disp_val1 = alu_res;
                w_disp_dep1 = 1'b0;
            end else if (lsb_ready && lsb_id == dec_tag1) begin
                w_disp_val1 = lsb_res;
                w_disp_dep1 = 1'b0;
            end
        end
        if (dec_dep2) begin
            if (alu_ready && alu_id == dec_tag2) begin
                w_disp_val2 = alu_res;
                w_disp_dep2 = 1'b0;
            end else if (lsb_ready && lsb_id == dec_tag2) begin
                w_disp_val2 = lsb_res;
                w_disp_dep2 = 1'b0;
            end
        end
    end

    // Entry update: dispatch into the free slot, release the issued slot, apply wakeups
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_dep1 <= '0;
            r_dep2 <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_busy <= '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (w_disp && w_free_idx == RS_SIZE_WIDTH'(i)) begin
                        r_busy[i] <= 1'b1;
                        r_op[i]   <= dec_op;
                        r_val1[i] <= w_disp_val1;
                        r_val2[i] <= w_disp_val2;
                        r_dep1[i] <= w_disp_dep1;
                        r_dep2[i] <= w_disp_dep2;
                        r_tag1[i] <= dec_tag1;
                        r_tag2[i] <= dec_tag2;
                        r_id[i]   <= dec_id;
                    end else begin
                        if (w_issue_found && w_issue_idx == RS_SIZE_WIDTH'(i)) begin
                            r_busy[i] <= 1'b0;
                        end
                        if (w_wk1[i]) begin
                            r_val1[i] <= w_wk1_val[i];
                            r_dep1[i] <= 1'b0;
                        end
                        if (w_wk2[i]) begin
                            r_val2[i] <= w_wk2_val[i];
                            r_dep2[i] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Issue register: present the selected entry to the ALU, hold payload when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_ready <= 1'b0;
            rs_op    <= '0;
            rs_val1  <= '0;
            rs_val2  <= '0;
            rs_id    <= '0;
        end else if (rdy) begin
            if (flush) begin
                rs_ready <= 1'b0;
            end else if (w_issue_found) begin
                rs_ready <= 1'b1;
                rs_op    <= r_op[w_issue_idx];
                rs_val1  <= r_val1[w_issue_idx];
                rs_val2  <= r_val2[w_issue_idx];
                rs_id    <= r_id[w_issue_idx];
            end else begin
                rs_ready <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_rs_scheduler.sv
// ============================================================================
// Module      : tb_alu_rs_scheduler
// Description : Self-checking bench for alu_rs_scheduler: a behavioural
//               reservation-station model compared every cycle, plus
//               hand-computed literal expectations for directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_rs_scheduler;
    import alu_rs_scheduler_pkg::*;

    localparam int NE = 1 << ALU_RS_SIZE_WIDTH;

    logic                      clk = 1'b0;
    logic                      rst, rdy, flush;
    logic                      dec_valid;
    logic [ALU_OP_WIDTH-1:0]   dec_op;
    logic [XLEN-1:0]           dec_val1, dec_val2;
    logic                      dec_dep1, dec_dep2;
    logic [ROB_SIZE_WIDTH-1:0] dec_tag1, dec_tag2, dec_id;
    logic                      alu_ready, lsb_ready;
    logic [XLEN-1:0]           alu_res, lsb_res;
    logic [ROB_SIZE_WIDTH-1:0] alu_id, lsb_id;
    logic                      rs_full, rs_ready;
    logic [ALU_OP_WIDTH-1:0]   rs_op;
    logic [XLEN-1:0]           rs_val1, rs_val2;
    logic [ROB_SIZE_WIDTH-1:0] rs_id;

    alu_rs_scheduler dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .dec_valid(dec_valid), .dec_op(dec_op),
        .dec_val1(dec_val1), .dec_val2(dec_val2),
        .dec_dep1(dec_dep1), .dec_dep2(dec_dep2),
        .dec_tag1(dec_tag1), .dec_tag2(dec_tag2), .dec_id(dec_id),
        .alu_ready(alu_ready), .alu_res(alu_res), .alu_id(alu_id),
        .lsb_ready(lsb_ready), .lsb_res(lsb_res), .lsb_id(lsb_id),
        .rs_full(rs_full), .rs_ready(rs_ready), .rs_op(rs_op),
        .rs_val1(rs_val1), .rs_val2(rs_val2), .rs_id(rs_id)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic                      busy;
        logic [ALU_OP_WIDTH-1:0]   op;
        logic [XLEN-1:0]           v1, v2;
        logic                      d1, d2;
        logic [ROB_SIZE_WIDTH-1:0] t1, t2, id;
    } ent_t;

    typedef struct packed {
        logic                      ready;
        logic [ALU_OP_WIDTH-1:0]   op;
        logic [XLEN-1:0]           v1, v2;
        logic [ROB_SIZE_WIDTH-1:0] id;
    } out_t;

    ent_t m_cur [NE];
    ent_t m_nxt [NE];
    out_t mo_cur, mo_nxt;
    bit   m_active = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Operand resolution against the current broadcasts (ALU first)
    function automatic void resolve(input logic dep, input logic [ROB_SIZE_WIDTH-1:0] tag,
                                    input logic [XLEN-1:0] val,
                                    output logic [XLEN-1:0] v, output logic d);
        v = val;
        d = dep;
        if (dep) begin
            if (alu_ready && alu_id == tag) begin v = alu_res; d = 1'b0; end
            else if (lsb_ready && lsb_id == tag) begin v = lsb_res; d = 1'b0; end
        end
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < NE; i++) if (!m_cur[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // Predict the state after the coming edge from current state and inputs
    task automatic compute_next();
        int iss;
        int fr;
        for (int i = 0; i < NE; i++) m_nxt[i] = m_cur[i];
        mo_nxt = mo_cur;
        iss = -1;
        fr  = -1;
        if (rst) begin
            for (int i = 0; i < NE; i++) m_nxt[i].busy = 1'b0;
            mo_nxt = '0;
        end else if (rdy) begin
            if (flush) begin
                for (int i = 0; i < NE; i++) m_nxt[i].busy = 1'b0;
                mo_nxt.ready = 1'b0;
            end else begin
                for (int i = NE - 1; i >= 0; i--) begin
                    if (m_cur[i].busy && !m_cur[i].d1 && !m_cur[i].d2) iss = i;
                    if (!m_cur[i].busy) fr = i;
                end
                if (iss >= 0) begin
                    mo_nxt = '{1'b1, m_cur[iss].op, m_cur[iss].v1, m_cur[iss].v2, m_cur[iss].id};
                    m_nxt[iss].busy = 1'b0;
                end else begin
                    mo_nxt.ready = 1'b0;
                end
                for (int i = 0; i < NE; i++) begin
                    if (m_cur[i].busy) begin
                        resolve(m_cur[i].d1, m_cur[i].t1, m_cur[i].v1, m_nxt[i].v1, m_nxt[i].d1);
                        resolve(m_cur[i].d2, m_cur[i].t2, m_cur[i].v2, m_nxt[i].v2, m_nxt[i].d2);
                    end
                end
                if (dec_valid) begin
                    if (fr < 0) begin
                        check("dispatch_while_full", 64'(dec_valid), 64'd0);
                    end else begin
                        m_nxt[fr].busy = 1'b1;
                        m_nxt[fr].op   = dec_op;
                        m_nxt[fr].t1   = dec_tag1;
                        m_nxt[fr].t2   = dec_tag2;
                        m_nxt[fr].id   = dec_id;
                        resolve(dec_dep1, dec_tag1, dec_val1, m_nxt[fr].v1, m_nxt[fr].d1);
                        resolve(dec_dep2, dec_tag2, dec_val2, m_nxt[fr].v2, m_nxt[fr].d2);
                    end
                end
            end
        end
    endtask

    // One clock: predict, let the edge happen, commit the prediction
    task automatic cyc();
        compute_next();
        @(posedge clk);
        #1;
        for (int i = 0; i < NE; i++) m_cur[i] = m_nxt[i];
        mo_cur = mo_nxt;
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (m_active) begin
            check("rs_ready", 64'(rs_ready), 64'(mo_cur.ready));
            check("rs_op",    64'(rs_op),    64'(mo_cur.op));
            check("rs_val1",  64'(rs_val1),  64'(mo_cur.v1));
            check("rs_val2",  64'(rs_val2),  64'(mo_cur.v2));
            check("rs_id",    64'(rs_id),    64'(mo_cur.id));
            check("rs_full",  64'(rs_full),  64'(model_full()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        dec_valid = 0; dec_op = '0; dec_val1 = '0; dec_val2 = '0;
        dec_dep1 = 0; dec_dep2 = 0; dec_tag1 = '0; dec_tag2 = '0; dec_id = '0;
        alu_ready = 0; alu_res = '0; alu_id = '0;
        lsb_ready = 0; lsb_res = '0; lsb_id = '0;
        flush = 0;
    endtask

    task automatic disp(input logic [ALU_OP_WIDTH-1:0] op,
                        input logic [XLEN-1:0] v1, input logic d1, input logic [ROB_SIZE_WIDTH-1:0] t1,
                        input logic [XLEN-1:0] v2, input logic d2, input logic [ROB_SIZE_WIDTH-1:0] t2,
                        input logic [ROB_SIZE_WIDTH-1:0] id);
        dec_valid = 1; dec_op = op; dec_val1 = v1; dec_dep1 = d1; dec_tag1 = t1;
        dec_val2 = v2; dec_dep2 = d2; dec_tag2 = t2; dec_id = id;
    endtask

    task automatic alu_bcast(input logic [ROB_SIZE_WIDTH-1:0] id, input logic [XLEN-1:0] res);
        alu_ready = 1; alu_id = id; alu_res = res;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < NE; i++) m_cur[i] = '0;
        mo_cur = '0;
        idle_inputs();
        rdy = 1;
        rst = 1;
        cyc();
        m_active = 1'b1;
        cyc();
        rst = 0;

        // Reset state then idle
        for (int k = 0; k < 5; k++) cyc();
        check("reset_ready", 64'(rs_ready), 64'd0);
        check("reset_full",  64'(rs_full),  64'd0);
        check("reset_id",    64'(rs_id),    64'd0);
        check("reset_val1",  64'(rs_val1),  64'd0);

        // Ready-at-dispatch ADD issues one cycle later
        disp(ALU_ADD, 32'd5, 0, '0, 32'd7, 0, '0, 4'd3);
        cyc();
        idle_inputs();
        cyc();
        check("add_ready", 64'(rs_ready), 64'd1);
        check("add_op",    64'(rs_op),    64'(ALU_ADD));
        check("add_val1",  64'(rs_val1),  64'd5);
        check("add_val2",  64'(rs_val2),  64'd7);
        check("add_id",    64'(rs_id),    64'd3);
        cyc();
        check("add_drop",  64'(rs_ready), 64'd0);

        // SUB waiting on tag 4, woken by ALU broadcast
        disp(ALU_SUB, 32'd0, 1, 4'd4, 32'd1, 0, '0, 4'd6);
        cyc();
        idle_inputs();
        cyc();
        check("sub_wait", 64'(rs_ready), 64'd0);
        alu_bcast(4'd4, 32'd10);
        cyc();
        idle_inputs();
        check("sub_not_yet", 64'(rs_ready), 64'd0);
        cyc();
        check("sub_ready", 64'(rs_ready), 64'd1);
        check("sub_val1",  64'(rs_val1),  64'd10);
        check("sub_val2",  64'(rs_val2),  64'd1);
        check("sub_id",    64'(rs_id),    64'd6);
        cyc();

        // Dispatch bypass from the LSB bus
        disp(ALU_AND, 32'd3, 0, '0, 32'd0, 1, 4'd2, 4'd1);
        lsb_ready = 1; lsb_id = 4'd2; lsb_res = 32'hFFFF_FFFF;
        cyc();
        idle_inputs();
        cyc();
        check("byp_ready", 64'(rs_ready), 64'd1);
        check("byp_val2",  64'(rs_val2),  64'hFFFF_FFFF);
        check("byp_id",    64'(rs_id),    64'd1);
        cyc();

        // Fill all entries waiting on tag 7, then drain in entry order
        for (int k = 0; k < NE; k++) begin
            disp(ALU_OR, 32'd0, 1, 4'd7, 32'(k), 0, '0, 4'(k));
            cyc();
        end
        idle_inputs();
        check("fill_full", 64'(rs_full), 64'd1);
        alu_bcast(4'd7, 32'd9);
        cyc();
        idle_inputs();
        for (int k = 0; k < NE; k++) begin
            cyc();
            check("drain_ready", 64'(rs_ready), 64'd1);
            check("drain_id",    64'(rs_id),    64'(k));
            check("drain_val1",  64'(rs_val1),  64'd9);
            if (k == 0) check("drain_full_drop", 64'(rs_full), 64'd0);
        end
        cyc();
        check("drain_done", 64'(rs_ready), 64'd0);

        // Flush while issuing; same-cycle dispatch is dropped
        for (int k = 0; k < 4; k++) begin
            disp(ALU_XOR, 32'd0, 1, 4'd5, 32'd2, 0, '0, 4'(10 + k));
            cyc();
        end
        idle_inputs();
        alu_bcast(4'd5, 32'd20);
        cyc();
        idle_inputs();
        cyc();
        check("pre_flush_ready", 64'(rs_ready), 64'd1);
        check("pre_flush_id",    64'(rs_id),    64'd10);
        flush = 1;
        disp(ALU_ADD, 32'd1, 0, '0, 32'd1, 0, '0, 4'd14);
        cyc();
        idle_inputs();
        check("flush_ready", 64'(rs_ready), 64'd0);
        check("flush_full",  64'(rs_full),  64'd0);
        for (int k = 0; k < 3; k++) cyc();
        check("flush_quiet", 64'(rs_ready), 64'd0);

        // rdy low freezes everything, including a ready issue
        for (int k = 0; k < 3; k++) begin
            disp(ALU_SLT, 32'd0, 1, 4'd9, 32'd4, 0, '0, 4'(1 + k));
            cyc();
        end
        idle_inputs();
        alu_bcast(4'd9, 32'h55);
        cyc();
        idle_inputs();
        cyc();
        check("rdy_pre_id", 64'(rs_id), 64'd1);
        rdy = 0;
        alu_bcast(4'd9, 32'h77);
        disp(ALU_SRA, 32'd8, 0, '0, 32'd8, 0, '0, 4'd15);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("frz_ready", 64'(rs_ready), 64'd1);
            check("frz_id",    64'(rs_id),    64'd1);
            check("frz_val1",  64'(rs_val1),  64'h55);
        end
        rdy = 1;
        idle_inputs();
        cyc();
        check("thaw_id2", 64'(rs_id), 64'd2);
        cyc();
        check("thaw_id3", 64'(rs_id), 64'd3);
        cyc();
        check("thaw_done", 64'(rs_ready), 64'd0);
        cyc();

        m_active = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_rs_scheduler.md
# alu_rs_scheduler

Reservation station and issue scheduler for the integer ALU. Holds up to 2^RS_SIZE_WIDTH dispatched ALU instructions and captures pending operands from the ALU and load/store result broadcasts. Each cycle it issues at most one fully-ready entry into the single-cycle ALU. It sits between the decoder/dispatch stage and the ALU and drives the ALU's rs_* inputs directly.

## Interface
- RS_SIZE_WIDTH, 3, log2 of entry count (8 entries)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low = hold all state
- flush  in  1  misprediction flush; discard all entries
- dec_valid  in  1  dispatch request (only when rs_full low)
- dec_op  in  `ALU_OP_WIDTH  ALU opcode
- dec_val1 / dec_val2  in  `XLEN  operand values (valid when matching has_dep low)
- dec_dep1 / dec_dep2  in  1  operand still pending
- dec_tag1 / dec_tag2  in  `ROB_SIZE_WIDTH  ROB id producing pending operand
- dec_id  in  `ROB_SIZE_WIDTH  ROB id of instruction
- alu_ready, alu_res, alu_id  in  1/`XLEN/`ROB_SIZE_WIDTH  ALU result broadcast
- lsb_ready, lsb_res, lsb_id  in  1/`XLEN/`ROB_SIZE_WIDTH  load/store result broadcast
- rs_full  out  1  all entries busy (combinational from busy bits)
- rs_ready  out  1  issue valid to ALU (registered)
- rs_op  out  `ALU_OP_WIDTH  issued opcode (registered)
- rs_val1 / rs_val2  out  `XLEN  issued operands (registered)
- rs_id  out  `ROB_SIZE_WIDTH  issued ROB id (registered)

## Operation
- Per entry: busy, op, val1, val2, dep1, dep2, tag1, tag2, id.
- Dispatch: on dec_valid, write to the lowest-index free entry. For each operand with dep set, if alu_ready && alu_id==tag (or the same for lsb) in the same cycle, store the broadcast value and clear dep (dispatch bypass). Priority is ALU over LSB on equal tags; equal tags cannot legally occur.
- Wakeup: every busy entry with depN set and a matching broadcast tag latches the value and clears depN.
- Ready entry: busy && !dep1 && !dep2, using registered state only. An entry woken this cycle is eligible next cycle.
- Issue: select the lowest-index ready entry. Register op/val/id onto rs_*, set rs_ready=1, clear busy. If none is ready, rs_ready=0 and the other rs_* outputs hold.
- Dispatch with rs_full high is illegal; the bench asserts on it. The design ignores it.
- An entry freed by issue is available for dispatch the following cycle, not the same cycle.
- flush (rdy high): clear all busy, rs_ready<=0. A same-cycle dispatch is dropped.
- rdy low: no state change. Outputs hold, including rs_ready.
- rst: all busy=0, rs_ready=0, rs_op=0, rs_val1=0, rs_val2=0, rs_id=0. rs_full=0 follows.
- rst has priority over flush; flush has priority over dispatch/issue/wakeup.

## Timing
- Dispatch at edge N → entry busy after N. If both operands are ready, it issues at edge N+1 (rs_ready high in cycle N+1), and the ALU result is valid after edge N+2.
- Back-to-back dependency: the ALU broadcasts id X in cycle M. A waiting entry captures at edge M and issues at edge M+1. Minimum dependent spacing is 2 cycles.
- One dispatch, one issue and up to two wakeups per cycle, all concurrent.
- rs_full reflects post-edge busy bits. The decoder samples it in the same cycle it drives dec_valid.

## Structure
- `XLEN, `ALU_OP_WIDTH, `ROB_SIZE_WIDTH and the ALU opcodes come from global_params.v. Add `ALU_RS_SIZE_WIDTH there as the default for RS_SIZE_WIDTH.
- Sub-module rs_picker (parameterized width): lowest-index-set-bit finder returning {found, index}. It is instantiated twice, once for the free vector and once for the ready vector.
- Entry storage as per-field arrays indexed by entry. The wakeup compare is a generate loop over entries.

## Test plan
- Reset, then idle 5 cycles → rs_ready=0, rs_* all zero, rs_full=0.
- Dispatch ADD val1=5, val2=7, id=3, no deps → next cycle rs_ready=1, rs_op=ALU_ADD, rs_val1=5, rs_val2=7, rs_id=3; the cycle after, rs_ready=0.
- Dispatch SUB dep1 tag=4, val2=1, id=6; two cycles later pulse alu_ready, alu_id=4, alu_res=10 → issue the following cycle with rs_val1=10, rs_val2=1, rs_id=6.
- Dispatch an entry with dep2 tag=2 in the same cycle as lsb_ready, lsb_id=2, lsb_res=0xFFFF_FFFF → bypass captured; issues next cycle with rs_val2=0xFFFF_FFFF.
- Dispatch 8 entries all waiting on tag 7 → rs_full=1. Broadcast alu_id=7, res=9 → issues ids in entry order 0..7 on 8 consecutive cycles; rs_full drops after the first issue.
- Fill 4 ready entries, assert flush while rs_ready=1 → next cycle rs_ready=0, rs_full=0, no further issues. Toggling rdy low mid-sequence freezes all outputs.
